pipe_flow_ctrl: RTL and testbench
=================================

Name: pipe_flow_ctrl

Overview:
- Hazard and flow controller for the 5-stage pipeline.
- Sequences the execute stage and the stages around it: stalls, bubble insertion, flushes, front-end redirects.
- Handles load-use stalls, data-memory wait states with a timeout, and halts on an execute-stage trap until software or a debugger restarts the core.
- Sits beside the pipeline registers; drives only their enable and clear inputs and the PC-select mux.

Parameters:
- TIMEOUT, 16: maximum number of MEM_WAIT cycles before a bus-error trap; legal range 2..255.
- TRAP_VEC, 32'h0000_0100: PC loaded on restart from TRAP.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active-low.
- rs1_ID  in  5  source register 1 of the instruction in ID.
- rs2_ID  in  5  source register 2 of the instruction in ID.
- opcode_ID  in  7  opcode in ID, OPTYPE.vh encoding.
- rd_EX  in  5  destination register of the instruction in EX.
- opcode_EX  in  7  opcode in EX.
- br_taken_EX  in  1  branch compare result from EX (res[0]).
- target_EX  in  32  jump/branch target computed for EX.
- trap_EX  in  1  trap flag from EX.
- dmem_req_MEM  in  1  load/store in MEM is issuing a data-memory access.
- dmem_ack  in  1  data memory completes the access this cycle.
- restart  in  1  leave TRAP.
- stall_IF  out  1  hold PC and IF/ID.
- stall_ID  out  1  hold ID/EX input side.
- stall_EX  out  1  hold EX/MEM and MEM/WB.
- bubble_EX  out  1  load a NOP into ID/EX.
- flush_ID  out  1  clear IF/ID.
- redirect  out  1  PC takes redirect_pc next edge.
- redirect_pc  out  32  new PC.
- halted  out  1  core is in TRAP.
- bus_err  out  1  sticky: a data-memory timeout occurred.

Behaviour:
- States: RUN, MEM_WAIT, TRAP, encoded in 2 bits. Outputs are Mealy, i.e. a function of state and current inputs. Only state, wait_cnt and bus_err are registered.
- Reset (reset_n low at a clk edge): state=RUN, wait_cnt=0, bus_err=0. While reset_n is low, all outputs are forced to 0 and redirect_pc is forced to 0.
- Operand use:
  - rs1 is used unless opcode_ID is LUI, AUIPC or JAL.
  - rs2 is used only for REG_OP, STORE and BRANCH.
- RUN, evaluated in priority order, highest first:
  1. trap_EX=1 → stall_IF=1, flush_ID=1, bubble_EX=1; next state TRAP.
  2. dmem_req_MEM=1 and dmem_ack=0 → stall_IF=stall_ID=stall_EX=1; wait_cnt←1; next state MEM_WAIT. If dmem_ack=1 in the same cycle, there is no stall.
  3. Redirect: (opcode_EX=BRANCH and br_taken_EX=1) or opcode_EX is JAL or JALR → redirect=1, redirect_pc=target_EX, flush_ID=1, bubble_EX=1.
  4. Load-use: opcode_EX=LOAD, rd_EX≠0, and rd_EX matches a used rs of ID → stall_IF=stall_ID=1, bubble_EX=1 for exactly one cycle. The bubble removes the condition; MEM forwarding supplies the data afterwards.
  5. Otherwise all outputs are 0.
- MEM_WAIT:
  - stall_IF, stall_ID and stall_EX stay at 1 until dmem_ack.
  - dmem_ack=1 → all stalls drop in that same cycle; next state RUN; wait_cnt←0.
  - No ack and wait_cnt=TIMEOUT-1 → bus_err←1; next state TRAP. The stalls remain set in this cycle.
  - Otherwise wait_cnt←wait_cnt+1.
  - trap_EX is ignored in MEM_WAIT because EX is frozen.
- TRAP:
  - halted=1 and stall_IF=stall_ID=stall_EX=1. trap_EX and dmem_ack are ignored.
  - restart=1 → stalls drop; redirect=1, redirect_pc=TRAP_VEC, flush_ID=1, bubble_EX=1; next state RUN; halted drops in the same cycle.
  - bus_err is cleared only by reset.
- wait_cnt is 8 bits and never wraps. Reset while in MEM_WAIT or TRAP returns the block to RUN with no pending redirect.

Optional Feature:
- Macro PIPE_FLOW_CTRL_PERF_EN. When defined, adds three 32-bit output ports:
  - perf_stall: cycles in which stall_IF=1.
  - perf_flush: cycles in which flush_ID=1.
  - perf_memwait: cycles spent in MEM_WAIT.
- All three counters reset to 0 under reset_n, wrap modulo 2^32 and keep counting in TRAP.
- When the macro is undefined, these ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Load-use: opcode_EX=LOAD, rd_EX=5, opcode_ID=REG_OP, rs2_ID=5 → one cycle with stall_IF=stall_ID=bubble_EX=1. The next cycle with opcode_EX=NOP → all outputs 0. The same case with rd_EX=0 → no stall.
- Taken branch: opcode_EX=BRANCH, br_taken_EX=1, target_EX=32'h40 → redirect=1, redirect_pc=32'h40, flush_ID=1, bubble_EX=1. With br_taken_EX=0 → all outputs 0.
- Memory wait: dmem_req_MEM=1, ack after 3 cycles → stall_EX=1 for 3 cycles, state returns to RUN, bus_err=0.
- Timeout: TIMEOUT=4, dmem_req_MEM=1, no ack → TRAP entered after 4 stall cycles with bus_err=1 and halted=1. restart → redirect_pc=32'h100, halted=0.
- Priority: trap_EX=1 together with a JAL in EX → no redirect, state TRAP. Reset asserted in TRAP → all outputs 0 and bus_err=0.
- With PIPE_FLOW_CTRL_PERF_EN: the timeout scenario with TIMEOUT=4 → perf_memwait=4.

Source files
------------

// File: rtl/pipe_flow_ctrl.sv
// Hazard/flow controller: load-use stalls, redirects, mem wait timeout, trap halt.
// Optional perf counters: define PIPE_FLOW_CTRL_PERF_EN.
module pipe_flow_ctrl #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [6:0]  opcode_ID,
  input  logic [4:0]  rd_EX,
  input  logic [6:0]  opcode_EX,
  input  logic        br_taken_EX,
  input  logic [31:0] target_EX,
  input  logic        trap_EX,
  input  logic        dmem_req_MEM,
  input  logic        dmem_ack,
  input  logic        restart,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        bubble_EX,
  output logic        flush_ID,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        halted,
  output logic        bus_err
`ifdef PIPE_FLOW_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_memwait
`endif
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       bus_err_q, bus_err_d;

  logic rs1_use, rs2_use, load_use, redir_ex;
  logic s_if, s_id, s_ex, bub, fl, rdr, hlt;
  logic [31:0] rpc;

  // Operand usage and hazard detection for the ID/EX pair
  always_comb begin
    rs1_use = (opcode_ID != OP_LUI) &&
              (opcode_ID != OP_AUIPC) &&
              (opcode_ID != OP_JAL);
    rs2_use = (opcode_ID == OP_REG) ||
              (opcode_ID == OP_STORE) ||
              (opcode_ID == OP_BRANCH);
    load_use = (opcode_EX == OP_LOAD) &&
               (rd_EX != 5'd0) &&
               ((rs1_use && (rs1_ID == rd_EX)) ||
                (rs2_use && (rs2_ID == rd_EX)));
    redir_ex = ((opcode_EX == OP_BRANCH) && br_taken_EX) ||
               (opcode_EX == OP_JAL) ||
               (opcode_EX == OP_JALR);
  end

  // Next state and Mealy outputs; outputs forced low during reset
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    s_if = 1'b0;
    s_id = 1'b0;
    s_ex = 1'b0;
    bub  = 1'b0;
    fl   = 1'b0;
    rdr  = 1'b0;
    hlt  = 1'b0;
    rpc  = 32'h0;
    case (state_q)
      RUN: begin
        if (trap_EX) begin
          s_if    = 1'b1;
          fl      = 1'b1;
          bub     = 1'b1;
          state_d = TRAP;
        end else if (dmem_req_MEM && !dmem_ack) begin
          s_if       = 1'b1;
          s_id       = 1'b1;
          s_ex       = 1'b1;
          wait_cnt_d = 8'd1;
          state_d    = MEM_WAIT;
        end else if (redir_ex) begin
          rdr = 1'b1;
          rpc = target_EX;
          fl  = 1'b1;
          bub = 1'b1;
        end else if (load_use) begin
          s_if = 1'b1;
          s_id = 1'b1;
          bub  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          wait_cnt_d = 8'd0;
          state_d    = RUN;
        end else begin
          s_if = 1'b1;
          s_id = 1'b1;
          s_ex = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            bus_err_d = 1'b1;
            state_d   = TRAP;
          end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      TRAP: begin
        if (restart) begin
          rdr     = 1'b1;
          rpc     = TRAP_VEC;
          fl      = 1'b1;
          bub     = 1'b1;
          state_d = RUN;
        end else begin
          hlt  = 1'b1;
          s_if = 1'b1;
          s_id = 1'b1;
          s_ex = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output gating: nothing escapes while reset is held
  always_comb begin
    stall_IF    = reset_n & s_if;
    stall_ID    = reset_n & s_id;
    stall_EX    = reset_n & s_ex;
    bubble_EX   = reset_n & bub;
    flush_ID    = reset_n & fl;
    redirect    = reset_n & rdr;
    halted      = reset_n & hlt;
    bus_err     = reset_n & bus_err_q;
    redirect_pc = reset_n ? rpc : 32'h0;
  end

  // State, wait counter and sticky bus error
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

`ifdef PIPE_FLOW_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q, perf_memwait_q;
  logic        memwait_cyc;

  // Memory-wait cycles include the entry cycle that raised the stall
  assign memwait_cyc = (state_q == MEM_WAIT) ||
                       (state_d == MEM_WAIT);

  // Free-running event counters, wrap naturally
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_stall_q   <= 32'h0;
      perf_flush_q   <= 32'h0;
      perf_memwait_q <= 32'h0;
    end else begin
      perf_stall_q   <= perf_stall_q + {31'h0, stall_IF};
      perf_flush_q   <= perf_flush_q + {31'h0, flush_ID};
      perf_memwait_q <= perf_memwait_q + {31'h0, memwait_cyc};
    end
  end

  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
  assign perf_memwait = perf_memwait_q;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl.
// Output vector: {sIF,sID,sEX,bub,flush,redir,halt,berr}.
module tb_pipe_flow_ctrl;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] REGOP  = 7'b0110011;
  localparam logic [6:0] IMMOP  = 7'b0010011;
  localparam logic [6:0] NOP    = 7'b0010011;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic [6:0] opcode_ID, opcode_EX;
  logic br_taken_EX, trap_EX, dmem_req_MEM, dmem_ack, restart;
  logic [31:0] target_EX;
  logic stall_IF, stall_ID, stall_EX, bubble_EX, flush_ID;
  logic redirect, halted, bus_err;
  logic [31:0] redirect_pc;
  logic [7:0] outs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_flow_ctrl #(.TIMEOUT(4), .TRAP_VEC(32'h100)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .opcode_ID(opcode_ID), .rd_EX(rd_EX),
    .opcode_EX(opcode_EX), .br_taken_EX(br_taken_EX),
    .target_EX(target_EX), .trap_EX(trap_EX),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ack(dmem_ack),
    .restart(restart),
    .stall_IF(stall_IF), .stall_ID(stall_ID),
    .stall_EX(stall_EX), .bubble_EX(bubble_EX),
    .flush_ID(flush_ID), .redirect(redirect),
    .redirect_pc(redirect_pc), .halted(halted),
    .bus_err(bus_err)
  );

  assign outs = {stall_IF, stall_ID, stall_EX, bubble_EX,
                 flush_ID, redirect, halted, bus_err};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_ID = 5'd1; rs2_ID = 5'd2; rd_EX = 5'd0;
    opcode_ID = NOP; opcode_EX = NOP;
    br_taken_EX = 1'b0; target_EX = 32'h0;
    trap_EX = 1'b0; dmem_req_MEM = 1'b0;
    dmem_ack = 1'b0; restart = 1'b0;
  endtask

  // Check settled outputs mid-cycle, then advance past the edge
  task automatic vec(input string tag,
                     input logic [7:0] eo,
                     input logic [31:0] epc);
    #3;
    chk(tag, {24'h0, outs}, {24'h0, eo});
    chk({tag, "_pc"}, redirect_pc, epc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    trap_EX = 1'b1; opcode_EX = JAL; target_EX = 32'h55;
    @(posedge clk); #1;
    vec("rst", 8'h00, 32'h0);
    idle();
    reset_n = 1'b1;
    vec("idle", 8'h00, 32'h0);

    opcode_EX = LOAD; rd_EX = 5'd5;
    opcode_ID = REGOP; rs2_ID = 5'd5;
    vec("lu_rs2", 8'b1101_0000, 32'h0);
    opcode_EX = NOP;
    vec("lu_after", 8'h00, 32'h0);
    opcode_EX = LOAD; rd_EX = 5'd0; rs2_ID = 5'd0;
    vec("lu_x0", 8'h00, 32'h0);
    idle();
    opcode_EX = LOAD; rd_EX = 5'd5;
    opcode_ID = LUI; rs1_ID = 5'd5;
    vec("lu_lui", 8'h00, 32'h0);
    opcode_ID = IMMOP;
    vec("lu_rs1", 8'b1101_0000, 32'h0);
    rs1_ID = 5'd1; rs2_ID = 5'd5;
    vec("lu_imm_rs2", 8'h00, 32'h0);

    idle();
    opcode_EX = BRANCH; br_taken_EX = 1'b1;
    target_EX = 32'h40;
    vec("br_t", 8'b0001_1100, 32'h40);
    br_taken_EX = 1'b0;
    vec("br_nt", 8'h00, 32'h0);
    opcode_EX = JALR; target_EX = 32'h1234;
    vec("jalr", 8'b0001_1100, 32'h1234);

    idle();
    dmem_req_MEM = 1'b1; dmem_ack = 1'b1;
    vec("mem_ack0", 8'h00, 32'h0);
    dmem_ack = 1'b0; opcode_EX = JAL; target_EX = 32'h80;
    vec("mw_1", 8'b1110_0000, 32'h0);
    opcode_EX = NOP;
    vec("mw_2", 8'b1110_0000, 32'h0);
    vec("mw_3", 8'b1110_0000, 32'h0);
    dmem_ack = 1'b1;
    vec("mw_ack", 8'h00, 32'h0);
    idle();
    vec("mw_run", 8'h00, 32'h0);

    dmem_req_MEM = 1'b1;
    vec("to_1", 8'b1110_0000, 32'h0);
    dmem_req_MEM = 1'b0;
    vec("to_2", 8'b1110_0000, 32'h0);
    vec("to_3", 8'b1110_0000, 32'h0);
    vec("to_4", 8'b1110_0000, 32'h0);
    vec("trap", 8'b1110_0011, 32'h0);
    trap_EX = 1'b1; dmem_ack = 1'b1;
    vec("trap_ign", 8'b1110_0011, 32'h0);
    idle();
    restart = 1'b1;
    vec("restart", 8'b0001_1101, 32'h100);
    idle();
    vec("post_rst", 8'b0000_0001, 32'h0);

    trap_EX = 1'b1; opcode_EX = JAL; target_EX = 32'h200;
    vec("prio", 8'b1001_1001, 32'h0);
    idle();
    vec("prio_trap", 8'b1110_0011, 32'h0);
    reset_n = 1'b0;
    vec("rst_trap", 8'h00, 32'h0);
    reset_n = 1'b1;
    vec("rst_run", 8'h00, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
